// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller that shares one 8-bit synchronous
//             RAM port between the IF and MEM pipeline stages. It builds
//             32-bit instruction fetches and sized loads/stores out of single
//             byte accesses. MEM requests take priority over IF requests.
//  Ports    :
//    clk, reset_n            clock, synchronous active-low reset
//    if_req / if_addr        instruction fetch request (4 bytes, little-endian)
//    if_ready / if_data      one-cycle completion pulse and fetched word
//    flush                   aborts an in-flight fetch, blocks fetch acceptance
//    mem_req/we/width/sext   data access request, direction, size, extension
//    mem_addr / mem_wdata    data byte address and store data
//    mem_ready / mem_rdata   one-cycle completion pulse and load result
//    ram_a/dout/wr/din       8-bit synchronous RAM port (1-cycle read latency)
//    stall_if / stall_mem    stage has an outstanding access (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              flush,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic              mem_sext,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IF   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [ADDR_W-1:0] r_base;      // first byte address of the access
    logic [ADDR_W-1:0] r_last_a;    // last address driven, held while idle
    logic [2:0]        r_cnt;       // byte step within the access
    logic [2:0]        r_nbytes;    // 1, 2 or 4
    logic [31:0]       r_wdata;
    logic              r_sext;
    logic [31:0]       r_buf;       // read bytes gathered so far

    logic              r_if_ready;
    logic              r_mem_ready;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic              w_ready_cycle;
    logic              w_accept_mem;
    logic              w_accept_if;
    logic [2:0]        w_req_nbytes;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [1:0]        w_lane;
    logic [31:0]       w_assembled;
    logic [31:0]       w_load_ext;

    // Only the low ADDR_W address bits reach the RAM.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^{if_addr, mem_addr};

    // ------------------------------------------------------------------------
    // Request acceptance. The cycle of a ready pulse is spent idle: the
    // requester still holds its request in that cycle, so it must not be
    // taken again.
    // ------------------------------------------------------------------------
    assign w_ready_cycle = r_if_ready | r_mem_ready;
    assign w_accept_mem  = reset_n & (r_state == S_IDLE) & ~w_ready_cycle & mem_req;
    assign w_accept_if   = reset_n & (r_state == S_IDLE) & ~w_ready_cycle & ~mem_req
                         & if_req & ~flush;

    always_comb begin
        w_req_nbytes = 3'd4;
        case (mem_width)
            2'd0:    w_req_nbytes = 3'd1;
            2'd1:    w_req_nbytes = 3'd2;
            default: w_req_nbytes = 3'd4;
        endcase
    end

    // Reads present addr+cnt in cycle c_cnt (cnt starts at 1) and capture the
    // byte presented one cycle earlier into lane cnt-1. Writes start cnt at 0
    // so that cycle c_i writes byte i-1.
    assign w_rd_last = (r_cnt == r_nbytes);
    assign w_wr_last = (r_cnt == (r_nbytes - 3'd1));
    assign w_lane    = 2'(r_cnt - 3'd1);

    // Final read word: the last byte comes straight from the RAM this cycle.
    always_comb begin
        w_assembled = r_buf;
        w_assembled[{w_lane, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        w_load_ext = w_assembled;
        case (r_nbytes)
            3'd1: w_load_ext = r_sext ? {{24{w_assembled[7]}}, w_assembled[7:0]}
                                      : {24'h0, w_assembled[7:0]};
            3'd2: w_load_ext = r_sext ? {{16{w_assembled[15]}}, w_assembled[15:0]}
                                      : {16'h0, w_assembled[15:0]};
            default: w_load_ext = w_assembled;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_mem) begin
                    w_next_state = mem_we ? S_WR : S_RD;
                end else if (w_accept_if) begin
                    w_next_state = S_IF;
                end
            end
            S_IF: begin
                // A redirect discards the partial fetch, even on its last byte.
                if (flush || w_rd_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD: begin
                if (w_rd_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR: begin
                if (w_wr_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: RAM port outputs. The address of a new access is driven in its
    // acceptance cycle so the first byte arrives one cycle later.
    // ------------------------------------------------------------------------
    always_comb begin
        ram_a    = r_last_a;
        ram_wr   = 1'b0;
        ram_dout = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_accept_mem) begin
                    ram_a = mem_addr[ADDR_W-1:0];
                end else if (w_accept_if) begin
                    ram_a = if_addr[ADDR_W-1:0];
                end
            end
            S_IF, S_RD: begin
                ram_a = r_base + ADDR_W'(r_cnt);
            end
            S_WR: begin
                ram_a    = r_base + ADDR_W'(r_cnt);
                ram_wr   = 1'b1;
                ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
            end
            default: begin
                ram_a = r_last_a;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_base      <= '0;
            r_last_a    <= '0;
            r_cnt       <= 3'd0;
            r_nbytes    <= 3'd0;
            r_wdata     <= 32'h0;
            r_sext      <= 1'b0;
            r_buf       <= 32'h0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else begin
            r_last_a    <= ram_a;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;

            if (w_accept_mem) begin
                r_base   <= mem_addr[ADDR_W-1:0];
                r_nbytes <= w_req_nbytes;
                r_wdata  <= mem_wdata;
                r_sext   <= mem_sext;
                r_cnt    <= mem_we ? 3'd0 : 3'd1;
                r_buf    <= 32'h0;
            end else if (w_accept_if) begin
                r_base   <= if_addr[ADDR_W-1:0];
                r_nbytes <= 3'd4;
                r_sext   <= 1'b0;
                r_cnt    <= 3'd1;
                r_buf    <= 32'h0;
            end

            case (r_state)
                S_IF: begin
                    if (!flush) begin
                        if (w_rd_last) begin
                            r_if_ready <= 1'b1;
                            r_if_data  <= w_assembled;
                        end else begin
                            r_buf[{w_lane, 3'b000} +: 8] <= ram_din;
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                S_RD: begin
                    if (w_rd_last) begin
                        r_mem_ready <= 1'b1;
                        r_mem_rdata <= w_load_ext;
                    end else begin
                        r_buf[{w_lane, 3'b000} +: 8] <= ram_din;
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WR: begin
                    if (w_wr_last) begin
                        r_mem_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_data   = r_if_data;
    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = mem_req & ~r_mem_ready;

endmodule
`default_nettype wire
